tlb_maint: RTL and testbench
============================

Name: tlb_maint

Overview:
- Owns the TLB entry array; drives `tlb_entrys` to the address-translation stage, which reads it combinationally for lookup.
- Executes the committed TLB-maintenance instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Sits at writeback, one op at a time, with a valid/ready handshake.
- INVTLB is a sequential walk of the array, one entry per cycle.

Parameters:
- TLB_ENTRY_NUM, 16: number of entries; must be a power of two.
- IDX_W, $clog2(TLB_ENTRY_NUM): entry index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- op_valid  in  1  op request
- op_ready  out  1  block idle, can accept
- op_type  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 reserved
- op_idx  in  IDX_W  entry index for RD/WR
- op_entry  in  89  entry for WR/FILL; tlb_entry_t = {vppn19, ps6, g1, asid10, e1, ppn0 20, plv0 2, mat0 2, d0 1, v0 1, ppn1 20, plv1 2, mat1 2, d1 1, v1 1}
- op_asid  in  10  ASID for SRCH/INV
- op_vppn  in  19  VA[31:13] for SRCH/INV
- inv_op  in  5  INVTLB op field
- done  out  1  one-cycle completion pulse
- srch_hit  out  1  SRCH result; valid while done
- srch_idx  out  IDX_W  lowest hit index; valid while done
- rd_entry  out  89  RD result; valid while done
- inv_op_err  out  1  INV with inv_op > 6; valid while done
- tlb_entrys  out  TLB_ENTRY_NUM x 89  registered entry array

Behaviour:
- **Reset (async, rst=1):**
  - All entries zeroed, so every e=0.
  - FSM to IDLE; fill counter = 0.
  - done, srch_hit, srch_idx, rd_entry, inv_op_err all 0; op_ready=0 while rst high.
- **FSM states:** IDLE, RESP, INV_WALK.
- **Handshake:** op accepted when op_valid & op_ready at edge T.
  - op_ready=1 only in IDLE.
  - All op_* inputs and inv_op are sampled at acceptance.
- **IDLE:** SRCH/RD/WR/FILL, or reserved op_type → RESP.
  - INV with inv_op ≤ 6 → INV_WALK, idx=0.
  - INV with inv_op > 6 → RESP.
- **RESP (cycle T+1):** done=1, results valid, → IDLE.
  - Back-to-back ops are therefore accepted at most every 2 cycles.
- **Entry match (SRCH and INV ops 5/6):** entry is valid if e=1.
  - VA match: if ps==21, compare vppn[18:9]; otherwise compare all 19 bits.
  - ASID match: asid==op_asid.
- **SRCH:** hit requires e=1 & (g | ASID match) & VA match.
  - srch_idx = lowest hitting index; 0 when no hit.
- **RD:** rd_entry = entry[op_idx], including entries with e=0.
- **WR:** entry[op_idx] = op_entry.
- **FILL:** entry[fill_cnt] = op_entry.
  - fill_cnt is a free-running IDX_W counter, +1 every cycle out of reset, wrapping N-1→0.
  - The value sampled is the one at acceptance edge T.
- **Write visibility:** tlb_entrys reflects WR/FILL from cycle T+1.
- **INV_WALK:** each cycle, if entry[idx] meets the condition for inv_op, clear its e; then idx++.
  - Conditions:
    - 0/1: always.
    - 2: g=1.
    - 3: g=0.
    - 4: g=0 & ASID match.
    - 5: g=0 & ASID match & VA match.
    - 6: (g=1 | ASID match) & VA match.
  - Only e is changed; all other fields are preserved.
  - At idx = N-1: done=1 in that same cycle, inv_op_err=0, → IDLE.
  - Total latency: done at T+N.
- **Reserved op_type:** done at T+1 with all results 0; no array change.
- **INV with inv_op > 6:** done at T+1 with inv_op_err=1; no array change.
- **Reset mid-walk:** array fully cleared, FSM to IDLE, and no done pulse is produced for the aborted op.
- **op_valid while busy:** ignored; the requester holds it until op_ready.

Optional Feature:
- Macro: TLB_INV_1CYCLE_EN.
- **Defined:** INV is applied to all entries in parallel at the T+1 edge, via the RESP path; done at T+1, and the INV_WALK state is removed.
- **Undefined:** serial walk with done at T+N, as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then RD idx 5 → done at T+1, rd_entry=0, e=0. Check every entry has e=0.
- WR idx 3 with {vppn=0x12345, ps=12, g=0, asid=0x2A, e=1}, then SRCH asid=0x2A vppn=0x12345 → srch_hit=1, srch_idx=3. Same SRCH with asid=0x2B → srch_hit=0.
- WR idx 7 with ps=21, vppn=0x12200, g=1, e=1; SRCH vppn=0x123FF, any asid → hit, idx=7 (upper 10 bits match).
- FILL accepted when fill_cnt=9 → entry 9 written; all other entries unchanged.
- Fill entries 0-15 alternating g=1/g=0, then INV op 3 → done exactly 16 cycles after accept (T+1 with TLB_INV_1CYCLE_EN). Only g=0 entries have e cleared; their other fields are intact.
- INV inv_op=9 → done at T+1, inv_op_err=1, array unchanged. Assert rst mid-walk → done never pulses, all e=0, op_ready returns 1 after reset release.

Source files
------------

// File: rtl/tlb_maint.sv
// tlb_maint: TLB entry array owner executing TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB at writeback
// Ports: clk/rst (async active-high); op_valid/op_ready handshake with op_type, op_idx,
// op_entry, op_asid, op_vppn, inv_op sampled at acceptance; done pulses on completion with
// srch_hit/srch_idx/rd_entry/inv_op_err valid; tlb_entrys is the registered array, flattened
// with entry i at bits [i*89 +: 89].
// Macro TLB_INV_1CYCLE_EN: apply INVTLB to all entries at once instead of a serial walk.
module tlb_maint #(
    parameter int TLB_ENTRY_NUM = 16,
    parameter int IDX_W = $clog2(TLB_ENTRY_NUM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [2:0]                 op_type,
    input  logic [IDX_W-1:0]           op_idx,
    input  logic [88:0]                op_entry,
    input  logic [9:0]                 op_asid,
    input  logic [18:0]                op_vppn,
    input  logic [4:0]                 inv_op,
    output logic                       done,
    output logic                       srch_hit,
    output logic [IDX_W-1:0]           srch_idx,
    output logic [88:0]                rd_entry,
    output logic                       inv_op_err,
    output logic [TLB_ENTRY_NUM*89-1:0] tlb_entrys
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RESP = 2'd1;
    localparam logic [1:0] S_WALK = 2'd2;

    // entry layout: vppn[88:70] ps[69:64] g[63] asid[62:53] e[52] page pair[51:0]
    function automatic logic va_match(input logic [88:0] e, input logic [18:0] vppn);
        return e[69:64] == 6'd21 ? e[88:79] == vppn[18:9] : e[88:70] == vppn;
    endfunction

    function automatic logic inv_cond(input logic [88:0] e, input logic [4:0] op,
                                      input logic [9:0] asid, input logic [18:0] vppn);
        logic g, am, va;
        g  = e[63];
        am = e[62:53] == asid;
        va = va_match(e, vppn);
        return op <= 5'd1 ? 1'b1 :
               op == 5'd2 ? g :
               op == 5'd3 ? !g :
               op == 5'd4 ? !g & am :
               op == 5'd5 ? !g & am & va :
               op == 5'd6 ? (g | am) & va : 1'b0;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] fill_q, hit_idx_c;
    logic [88:0]      ent_q [TLB_ENTRY_NUM];
    logic [4:0]       inv_op_q;
    logic [9:0]       asid_q;
    logic [18:0]      vppn_q;
    logic             srch_hit_q, inv_op_err_q, hit_c, accept, is_inv, inv_ok;
    logic [IDX_W-1:0] srch_idx_q;
    logic [88:0]      rd_entry_q;

    assign accept     = op_valid & op_ready;
    assign op_ready   = state_q == S_IDLE & ~rst;
    assign is_inv     = op_type == 3'd4;
    assign inv_ok     = inv_op <= 5'd6;
    assign srch_hit   = srch_hit_q;
    assign srch_idx   = srch_idx_q;
    assign rd_entry   = rd_entry_q;
    assign inv_op_err = inv_op_err_q;

    for (genvar g = 0; g < TLB_ENTRY_NUM; g++) begin : g_out
        assign tlb_entrys[g*89 +: 89] = ent_q[g];
    end

    // scan downward so the lowest hitting index is the one left standing
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--)
            if (ent_q[i][52] & (ent_q[i][63] | ent_q[i][62:53] == op_asid) & va_match(ent_q[i], op_vppn)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
    end

`ifdef TLB_INV_1CYCLE_EN
    logic inv_go_q;

    assign done    = state_q == S_RESP;
    assign state_d = accept ? S_RESP : S_IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) inv_go_q <= 1'b0;
        else     inv_go_q <= accept & is_inv & inv_ok;
`else
    logic [IDX_W-1:0] idx_q, idx_d;

    assign done    = state_q == S_RESP | (state_q == S_WALK & idx_q == IDX_W'(TLB_ENTRY_NUM - 1));
    assign idx_d   = state_q == S_WALK ? idx_q + 1'b1 : '0;
    assign state_d = state_q == S_IDLE ? (accept ? (is_inv & inv_ok ? S_WALK : S_RESP) : S_IDLE) :
                     state_q == S_WALK & ~done ? S_WALK : S_IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fill_q       <= '0;
            inv_op_q     <= '0;
            asid_q       <= '0;
            vppn_q       <= '0;
            srch_hit_q   <= 1'b0;
            srch_idx_q   <= '0;
            rd_entry_q   <= '0;
            inv_op_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_q + 1'b1;
            if (accept) begin
                inv_op_q     <= inv_op;
                asid_q       <= op_asid;
                vppn_q       <= op_vppn;
                srch_hit_q   <= op_type == 3'd0 & hit_c;
                srch_idx_q   <= op_type == 3'd0 ? hit_idx_c : '0;
                rd_entry_q   <= op_type == 3'd1 ? ent_q[op_idx] : '0;
                inv_op_err_q <= is_inv & ~inv_ok;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TLB_ENTRY_NUM; i++) ent_q[i] <= '0;
        end else begin
            if (accept & op_type == 3'd2) ent_q[op_idx] <= op_entry;
            if (accept & op_type == 3'd3) ent_q[fill_q] <= op_entry;
`ifdef TLB_INV_1CYCLE_EN
            if (inv_go_q)
                for (int i = 0; i < TLB_ENTRY_NUM; i++)
                    if (inv_cond(ent_q[i], inv_op_q, asid_q, vppn_q)) ent_q[i][52] <= 1'b0;
`else
            if (state_q == S_WALK && inv_cond(ent_q[idx_q], inv_op_q, asid_q, vppn_q))
                ent_q[idx_q][52] <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_tlb_maint.sv
// tb_tlb_maint: scoreboard bench for tlb_maint against a behavioural TLB model
module tb_tlb_maint;
    localparam int N = 16;
`ifdef TLB_INV_1CYCLE_EN
    localparam int INV_LAT = 1;
`else
    localparam int INV_LAT = N;
`endif

    logic          clk = 1'b0, rst = 1'b1, op_valid = 1'b0;
    logic          op_ready, done, srch_hit, inv_op_err;
    logic [2:0]    op_type = '0;
    logic [3:0]    op_idx = '0, srch_idx;
    logic [88:0]   op_entry = '0, rd_entry;
    logic [9:0]    op_asid = '0;
    logic [18:0]   op_vppn = '0;
    logic [4:0]    inv_op = '0;
    logic [N*89-1:0] tlb_entrys;

    tlb_maint dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
        .op_idx(op_idx), .op_entry(op_entry), .op_asid(op_asid), .op_vppn(op_vppn),
        .inv_op(inv_op), .done(done), .srch_hit(srch_hit), .srch_idx(srch_idx),
        .rd_entry(rd_entry), .inv_op_err(inv_op_err), .tlb_entrys(tlb_entrys)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [3:0]  idx;
        logic [88:0] rd;
        logic        err;
        int          lat;
        int          c_acc;
    } exp_t;

    exp_t        sb[$];
    logic [88:0] m [N];
    int          checks = 0, errors = 0, cyc = 0;
    logic [3:0]  fcnt;

    always @(posedge clk) cyc <= cyc + 1;

    // free-running fill pointer as the architecture defines it: counts cycles since reset, mod N
    always @(posedge clk or posedge rst)
        if (rst) fcnt <= '0;
        else     fcnt <= fcnt + 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [88:0] mk(input logic [18:0] vppn, input int ps, input bit g,
                                       input logic [9:0] asid, input bit e, input logic [51:0] low);
        return {vppn, 6'(ps), g, asid, e, low};
    endfunction

    // page of size 2^ps: a 2MB page ignores the low 9 bits of the VPPN
    function automatic bit va_ok(input logic [88:0] e, input logic [18:0] v);
        int sh = (e[69:64] == 21) ? 9 : 0;
        return (e[88:70] >> sh) == (v >> sh);
    endfunction

    function automatic bit inv_sel(input logic [88:0] e, input int op, input logic [9:0] a, input logic [18:0] v);
        bit g = e[63];
        bit am = e[62:53] == a;
        bit va = va_ok(e, v);
        case (op)
            0, 1: return 1;
            2: return g;
            3: return !g;
            4: return !g && am;
            5: return !g && am && va;
            6: return (g || am) && va;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("srch_hit", srch_hit, e.hit);
                check("srch_idx", srch_idx, e.idx);
                check("rd_entry", rd_entry, e.rd);
                check("inv_op_err", inv_op_err, e.err);
                check("latency", cyc - e.c_acc + 1, e.lat);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!op_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (fcnt != 4'(v) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (fcnt != 4'(v)) check("fill_cnt_timeout", fcnt, v);
    endtask

    // must be entered at a negedge with op_ready high
    task automatic do_op(input int t, input int idx, input logic [88:0] ent, input logic [9:0] asid,
                         input logic [18:0] vppn, input int iop, input bit push);
        exp_t e;
        e = '{hit: 0, idx: 0, rd: 0, err: 0, lat: 1, c_acc: cyc + 1};
        op_type = 3'(t); op_idx = 4'(idx); op_entry = ent; op_asid = asid; op_vppn = vppn;
        inv_op = 5'(iop); op_valid = 1'b1;
        case (t)
            0: for (int i = 0; i < N; i++)
                   if (!e.hit && m[i][52] && (m[i][63] || m[i][62:53] == asid) && va_ok(m[i], vppn)) begin
                       e.hit = 1;
                       e.idx = 4'(i);
                   end
            1: e.rd = m[idx];
            2: m[idx] = ent;
            3: m[fcnt] = ent;
            4: if (iop > 6) e.err = 1;
               else begin
                   e.lat = INV_LAT;
                   for (int i = 0; i < N; i++) if (inv_sel(m[i], iop, asid, vppn)) m[i][52] = 1'b0;
               end
            default: ;
        endcase
        if (push) sb.push_back(e);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic op(input int t, input int idx, input logic [88:0] ent, input logic [9:0] asid,
                      input logic [18:0] vppn, input int iop);
        wait_ready();
        do_op(t, idx, ent, asid, vppn, iop, 1);
    endtask

    task automatic settle();
        int n = 0;
        while ((sb.size() != 0 || !op_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        for (int i = 0; i < N; i++) check($sformatf("entry%0d", i), tlb_entrys[i*89 +: 89], m[i]);
    endtask

    logic [18:0] pool [4] = '{19'h12345, 19'h12200, 19'h0ABCD, 19'h7F000};

    initial begin
        for (int i = 0; i < N; i++) m[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_op_ready", op_ready, 0);
        check("rst_done", done, 0);
        check("rst_outputs", {srch_hit, srch_idx, rd_entry, inv_op_err}, 0);
        rst = 1'b0;

        op(1, 5, 0, 0, 0, 0); settle();
        op(2, 3, mk(19'h12345, 12, 0, 10'h2A, 1, 52'h0123456789ABC), 0, 0, 0); settle();
        op(0, 0, 0, 10'h2A, 19'h12345, 0); settle();
        op(0, 0, 0, 10'h2B, 19'h12345, 0); settle();
        op(2, 7, mk(19'h12200, 21, 1, 10'h155, 1, 52'hFEDCBA9876543), 0, 0, 0); settle();
        op(0, 0, 0, 10'h3FF, 19'h123FF, 0); settle();

        wait_ready(); wait_cnt(9);
        do_op(3, 0, mk(19'h00999, 14, 0, 10'h009, 1, 52'h9), 0, 0, 0, 1); settle();

        for (int i = 0; i < N; i++) begin
            wait_ready(); wait_cnt(i);
            do_op(3, 0, mk(19'(i * 19'h111), 12, i[0] == 0, 10'(i), 1, 52'(i * 7 + 1)), 0, 0, 0, 1);
        end
        settle();
        op(4, 0, 0, 0, 0, 3); settle();
        op(4, 0, 0, 0, 0, 9); settle();
        op(6, 0, 0, 0, 0, 0); settle();

        wait_ready();
        do_op(4, 0, 0, 0, 0, 0, 0);
        repeat (INV_LAT > 1 ? 5 : 0) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) m[i] = '0;
        #1 check("midrst_op_ready", op_ready, 0);
        check("midrst_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", op_ready, 1);
        repeat (N + 2) @(negedge clk);
        settle();

        for (int k = 0; k < 120; k++) begin
            int r = $urandom_range(9);
            logic [18:0] v = pool[$urandom_range(3)];
            logic [88:0] ent = mk(v, $urandom_range(1) ? 21 : 12, 1'($urandom), 10'($urandom_range(3)),
                                  $urandom_range(3) != 0, {20'($urandom), $urandom});
            logic [9:0] a = 10'($urandom_range(3));
            if ($urandom_range(1)) v[8:0] = 9'($urandom);
            if (r <= 2)      op(0, 0, 0, a, v, 0);
            else if (r == 3) op(1, $urandom_range(N - 1), 0, 0, 0, 0);
            else if (r <= 5) op(2, $urandom_range(N - 1), ent, 0, 0, 0);
            else if (r == 6) op(3, 0, ent, 0, 0, 0);
            else if (r <= 8) op(4, 0, 0, a, v, $urandom_range(9));
            else             op(5 + $urandom_range(2), $urandom_range(N - 1), ent, a, v, 0);
            settle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
